// File: rtl/matrix_fifo_loader.sv
// rtl/matrix_fifo_loader.sv - fetches matrix A rows and vector B from memory and streams their bytes into the MAC input FIFOs
module matrix_fifo_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int BASE_ADDR  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        mem_address,
    output logic                         mem_read,
    input  logic                         mem_waitrequest,
    input  logic [COLS*DATA_WIDTH-1:0]   mem_readdata,
    input  logic                         mem_readdatavalid,
    output logic [DATA_WIDTH-1:0]        fifo_wrdata,
    output logic [ROWS-1:0]              a_wrreq,
    input  logic [ROWS-1:0]              a_wrfull,
    output logic                         b_wrreq,
    input  logic                         b_wrfull
);
    localparam int W  = COLS * DATA_WIDTH;
    // Row counter runs 0..ROWS; the extra value ROWS selects the B vector word
    localparam int RW = $clog2(ROWS + 1);
    localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [BW-1:0]         byte_q, byte_d;
    logic [W-1:0]          word_q, word_d;

    logic                  target_b;
    logic                  target_full;
    logic [ROWS-1:0]       row_onehot;
    logic [DATA_WIDTH-1:0] cur_byte;

    // Decode the current row into a FIFO select and pick the element addressed by the byte counter
    always_comb begin
        row_onehot = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_onehot[r] = (row_q == RW'(r));
        end
        target_b    = (row_q == RW'(ROWS));
        // wrfull is used combinationally so a write lands in the first cycle the FIFO has room
        target_full = target_b ? b_wrfull : |(a_wrfull & row_onehot);
        cur_byte    = '0;
        for (int k = 0; k < COLS; k++) begin
            if (byte_q == BW'(k)) begin
                cur_byte = word_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and output logic: one read per word, then COLS single-cycle FIFO strobes
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        byte_d      = byte_q;
        word_d      = word_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        fifo_wrdata = '0;
        a_wrreq     = '0;
        b_wrreq     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    state_d = S_REQ;
                    row_d   = '0;
                    byte_d  = '0;
                end
            end
            S_REQ: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(row_q);
                if (!mem_waitrequest) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mem_readdatavalid) begin
                    word_d  = mem_readdata;
                    byte_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy        = 1'b1;
                fifo_wrdata = cur_byte;
                if (!target_full) begin
                    a_wrreq = target_b ? '0 : row_onehot;
                    b_wrreq = target_b;
                    if (byte_q == BW'(COLS - 1)) begin
                        byte_d = '0;
                        if (target_b) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = S_REQ;
                        end
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and word register; reset aborts any load in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
        end
    end
endmodule

// File: tb/tb_matrix_fifo_loader.sv
// tb/tb_matrix_fifo_loader.sv - directed self-checking bench for matrix_fifo_loader
module tb_matrix_fifo_loader;
    localparam int DW   = 8;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int AW   = 32;
    localparam int W    = COLS * DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_waitrequest;
    logic [W-1:0]  mem_readdata;
    logic          mem_readdatavalid;
    logic [DW-1:0] fifo_wrdata;
    logic [ROWS-1:0] a_wrreq;
    logic [ROWS-1:0] a_wrfull;
    logic          b_wrreq;
    logic          b_wrfull;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic          pend_n = 1'b0;
    logic          spur_n = 1'b0;
    logic          spur_req = 1'b0;
    logic [AW-1:0] addr_n = '0;

    logic [7:0] cap_a [ROWS][16];
    int         cnt_a [ROWS];
    logic [7:0] cap_b [16];
    int         cnt_b;
    int         strobes;
    int         done_cyc;
    int         done_busy;
    int         req2_cycles;
    int         r5b3_cyc;
    int         last_wr;

    matrix_fifo_loader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .fifo_wrdata       (fifo_wrdata),
        .a_wrreq           (a_wrreq),
        .a_wrfull          (a_wrfull),
        .b_wrreq           (b_wrreq),
        .b_wrfull          (b_wrfull)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        logic [W-1:0] w;
        w = '0;
        for (int c = 0; c < COLS; c++) begin
            if (a < ROWS) w[c*8 +: 8] = 8'(16 * a + c);
            else          w[c*8 +: 8] = 8'(8'hA0 + c);
        end
        return w;
    endfunction

    // Memory: accepts a read mid-cycle, returns data in the following cycle
    initial begin
        forever begin
            @(negedge clk);
            #1;
            pend_n = (mem_read === 1'b1) && (mem_waitrequest === 1'b0);
            addr_n = mem_address;
            spur_n = spur_req;
        end
    end

    initial begin
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_readdatavalid = pend_n | spur_n;
            mem_readdata      = pend_n ? mem_word(addr_n) : '1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (a_wrreq != '0 || b_wrreq) begin
            strobes++;
            last_wr = cyc;
            chk("strobe_onehot", 64'($countones({a_wrreq, b_wrreq})), 64'd1);
            chk("strobe_while_full", 64'({a_wrreq & a_wrfull, b_wrreq & b_wrfull}), 64'd0);
            for (int r = 0; r < ROWS; r++) begin
                if (a_wrreq[r]) begin
                    if (cnt_a[r] < 16) cap_a[r][cnt_a[r]] = fifo_wrdata;
                    if (r == 5 && cnt_a[r] == 3) r5b3_cyc = cyc;
                    cnt_a[r]++;
                end
            end
            if (b_wrreq) begin
                if (cnt_b < 16) cap_b[cnt_b] = fifo_wrdata;
                cnt_b++;
            end
        end
        if (mem_read && mem_address == 32'd2) req2_cycles++;
        if (done && done_cyc < 0) begin
            done_cyc  = cyc;
            done_busy = int'(busy);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic wait_rel(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wait_done(input int limit);
        while (done_cyc < 0 && cyc < limit) tick();
    endtask

    task automatic clear_caps();
        for (int r = 0; r < ROWS; r++) cnt_a[r] = 0;
        cnt_b       = 0;
        strobes     = 0;
        done_cyc    = -1;
        done_busy   = -1;
        req2_cycles = 0;
        r5b3_cyc    = -1;
        last_wr     = -1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
        chk({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        chk({tag, "_fifo_wrdata"}, 64'(fifo_wrdata), 64'd0);
        chk({tag, "_a_wrreq"}, 64'(a_wrreq), 64'd0);
        chk({tag, "_b_wrreq"}, 64'(b_wrreq), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_idle("reset");
    endtask

    task automatic start_load();
        clear_caps();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic verify(input string tag);
        for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("%s_cnt_a%0d", tag, r), 64'(cnt_a[r]), 64'd8);
            for (int c = 0; c < COLS; c++) begin
                chk($sformatf("%s_a%0d_%0d", tag, r, c), 64'(cap_a[r][c]), 64'(16 * r + c));
            end
        end
        chk({tag, "_cnt_b"}, 64'(cnt_b), 64'd8);
        for (int c = 0; c < COLS; c++) begin
            chk($sformatf("%s_b%0d", tag, c), 64'(cap_b[c]), 64'(8'hA0 + c));
        end
        chk({tag, "_strobes"}, 64'(strobes), 64'd72);
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        mem_waitrequest = 1'b0;
        a_wrfull        = '0;
        b_wrfull        = 1'b0;
        clear_caps();

        // Plain load with spurious readdatavalid (all ones) during row 0 WRITE
        do_reset();
        start_load();
        wait_rel(4);
        spur_req = 1'b1;
        tick();
        tick();
        spur_req = 1'b0;
        wait_done(300);
        chk("t1_done_cycle", 64'(done_cyc), 64'd91);
        chk("t1_busy_at_done", 64'(done_busy), 64'd0);
        chk("t1_last_write_cycle", 64'(last_wr), 64'd90);
        verify("t1");

        // waitrequest held for 3 cycles on row 2
        do_reset();
        start_load();
        wait_rel(21);
        mem_waitrequest = 1'b1;
        wait_rel(24);
        mem_waitrequest = 1'b0;
        wait_done(300);
        chk("t2_done_cycle", 64'(done_cyc), 64'd94);
        chk("t2_row2_req_cycles", 64'(req2_cycles), 64'd4);
        verify("t2");

        // A FIFO 5 full for 5 cycles at row 5 byte 3
        do_reset();
        start_load();
        wait_rel(56);
        a_wrfull = 8'h20;
        wait_rel(61);
        a_wrfull = 8'h00;
        wait_done(300);
        chk("t3_r5b3_cycle", 64'(r5b3_cyc), 64'd61);
        chk("t3_done_cycle", 64'(done_cyc), 64'd96);
        verify("t3");

        // reset mid-load, then reload from row 0
        do_reset();
        start_load();
        wait_rel(40);
        rst = 1'b1;
        wait_rel(41);
        rst = 1'b0;
        check_idle("t5_midrst");
        start_load();
        wait_done(300);
        chk("t5_done_cycle", 64'(done_cyc), 64'd91);
        verify("t5");

        // start held high through the load and into DONE
        do_reset();
        clear_caps();
        start = 1'b1;
        cyc   = 0;
        wait_done(300);
        chk("t6_done_cycle", 64'(done_cyc), 64'd91);
        chk("t6_done_dropped", 64'(done), 64'd0);
        chk("t6_busy_again", 64'(busy), 64'd1);
        chk("t6_mem_read", 64'(mem_read), 64'd1);
        chk("t6_mem_address", 64'(mem_address), 64'd0);
        verify("t6a");
        start = 1'b0;
        clear_caps();
        wait_done(400);
        chk("t6_second_done_cycle", 64'(done_cyc), 64'd182);
        verify("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
